// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ requesters, each with a 1-byte buffer.
// Byte captured at edge N is presented after edge N+1 at the earliest; tx_ready low holds the byte and lets buffers stall.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  buf_full;
  logic [DATA_W-1:0]   buf_data [NUM_REQ];
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     scan_id;
  logic                sel_vld;

  // First full buffer after the last grant, wrapping around.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    scan_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_id = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!sel_vld && buf_full[scan_id]) begin
        sel     = scan_id;
        sel_vld = 1'b1;
      end
    end
  end

  assign req_ready = ~buf_full;
  assign busy      = (|buf_full) | tx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      buf_full   <= '0;
      for (int i = 0; i < NUM_REQ; i++) buf_data[i] <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !buf_full[i]) begin
          buf_full[i] <= 1'b1;
          buf_data[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
      case (state)
        IDLE: begin
          // A buffer drained here only reads as ready next cycle, so no refill collides with the clear.
          if (sel_vld) begin
            tx_data       <= buf_data[sel];
            tx_valid      <= 1'b1;
            grant_id      <= sel;
            last_grant    <= sel;
            buf_full[sel] <= 1'b0;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_uart_tx_arbiter;
  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic         tx_ready = 1'b0;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic [1:0]   grant_id;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: pending bytes per requester, round-robin pointer, presented byte.
  bit         m_pend [N];
  logic [7:0] m_data [N];
  int         m_last;
  bit         m_valid;
  logic [7:0] m_txd;
  int         m_gid;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !m_pend[i];
    return r;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = m_valid;
    for (int i = 0; i < N; i++) b = b | m_pend[i];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_data[i] = 8'h00;
    end
    m_last  = N - 1;
    m_valid = 0;
    m_txd   = 8'h00;
    m_gid   = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then settle to the falling edge.
  task automatic cycle();
    bit [N-1:0] cap;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < N; i++) cap[i] = req_valid[i] && !m_pend[i];
      if (m_valid) begin
        if (tx_ready) m_valid = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j = (m_last + k) % N;
          if (m_pend[j]) begin
            m_pend[j] = 0;
            m_txd     = m_data[j];
            m_gid     = j;
            m_last    = j;
            m_valid   = 1;
            break;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (cap[i]) begin
          m_pend[i] = 1;
          m_data[i] = req_data[i*W +: W];
        end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (req_ready !== 3'b111) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 111", req_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    tx_ready  = 1'b1;
    req_valid = 3'b010;
    req_data  = {8'h00, 8'h44, 8'h00};
    cycle();
    req_valid = '0;
    tests_run++; if (req_ready !== 3'b101) begin tests_failed++; $display("FAIL single_capture_ready: got %b want 101", req_ready); end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_latency: got %b want 0", tx_valid); end
    cycle();
    tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b want 1", tx_valid); end
    tests_run++; if (tx_data !== 8'h44) begin tests_failed++; $display("FAIL single_data: got %h want 44", tx_data); end
    tests_run++; if (grant_id !== 2'd1) begin tests_failed++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    tests_run++; if (req_ready !== 3'b111) begin tests_failed++; $display("FAIL single_ready_back: got %b want 111", req_ready); end
    cycle();
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_one_cycle: got %b want 0", tx_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_all_three();
    logic [6:0] got_pat;
    logic [7:0] bytes [$];
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43;
    apply_reset();
    tx_ready  = 1'b1;
    req_valid = 3'b111;
    req_data  = {8'h43, 8'h42, 8'h41};
    cycle();
    req_valid = '0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      got_pat[c] = tx_valid;
      if (tx_valid) bytes.push_back(tx_data);
    end
    tests_run++; if (got_pat !== 7'b0010101) begin tests_failed++; $display("FAIL all3_spacing: got %b want 0010101", got_pat); end
    tests_run++; if (bytes.size() != 3) begin tests_failed++; $display("FAIL all3_count: got %0d want 3", bytes.size()); end
    for (int i = 0; i < 3 && i < bytes.size(); i++) begin
      tests_run++; if (bytes[i] !== exp_bytes[i]) begin tests_failed++; $display("FAIL all3_order[%0d]: got %h want %h", i, bytes[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_stall();
    int bad;
    apply_reset();
    tx_ready  = 1'b0;
    req_valid = 3'b001;
    req_data  = {16'h0, 8'hA5};
    cycle();
    req_valid = '0;
    cycle();
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin tests_failed++; $display("FAIL stall_first: got %b/%h want 1/a5", tx_valid, tx_data); end
    req_valid = 3'b001;
    req_data  = {16'h0, 8'h5A};
    cycle();
    req_valid = '0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      // An extra byte offered while the buffer is full must be ignored.
      if (c == 10) begin req_valid = 3'b001; req_data = {16'h0, 8'h77}; end
      else req_valid = '0;
      cycle();
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || req_ready[0] !== 1'b0) bad++;
    end
    req_valid = '0;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    tx_ready = 1'b1;
    cycle();
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release: got %b want 0", tx_valid); end
    cycle();
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A || grant_id !== 2'd0) begin tests_failed++; $display("FAIL stall_second: got %b/%h/%0d want 1/5a/0", tx_valid, tx_data, grant_id); end
    cycle();
    tests_run++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_drain: got busy %b valid %b want 0 0", busy, tx_valid); end
  endtask

  task automatic test_fairness();
    int ids [$];
    int exp_ids [4];
    int n2;
    exp_ids[0] = 0; exp_ids[1] = 2; exp_ids[2] = 0; exp_ids[3] = 0;
    apply_reset();
    tx_ready  = 1'b1;
    req_valid = 3'b101;
    req_data  = {8'hC2, 8'h00, 8'($urandom)};
    cycle();
    req_valid = 3'b001;
    for (int c = 0; c < 12; c++) begin
      req_data[7:0] = 8'($urandom);
      cycle();
      if (tx_valid) begin
        ids.push_back(int'(grant_id));
        tests_run++; if (tx_data !== m_txd) begin tests_failed++; $display("FAIL fair_data: got %h want %h", tx_data, m_txd); end
      end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= ids.size() || ids[i] != exp_ids[i]) begin
        tests_failed++;
        $display("FAIL fair_grant[%0d]: got %0d want %0d", i, (i < ids.size()) ? ids[i] : -1, exp_ids[i]);
      end
    end
    n2 = 0;
    foreach (ids[i]) if (ids[i] == 2) n2++;
    tests_run++; if (n2 != 1) begin tests_failed++; $display("FAIL fair_req2_once: got %0d want 1", n2); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tx_ready  = 1'b0;
    req_valid = 3'b111;
    req_data  = {8'h93, 8'h92, 8'h91};
    cycle();
    req_valid = '0;
    cycle();
    tests_run++; if (tx_valid !== 1'b1 || req_ready !== 3'b001) begin tests_failed++; $display("FAIL rmid_pre: got %b/%b want 1/001", tx_valid, req_ready); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
    tests_run++; if (req_ready !== 3'b111) begin tests_failed++; $display("FAIL rmid_req_ready: got %b want 111", req_ready); end
    tests_run++; if (busy !== 1'b0 || tx_data !== 8'h00) begin tests_failed++; $display("FAIL rmid_outputs: got busy %b data %h want 0 00", busy, tx_data); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    tx_ready  = 1'b1;
    req_valid = 3'b011;
    req_data  = {8'h00, 8'h22, 8'h11};
    cycle();
    req_valid = '0;
    cycle();
    tests_run++; if (tx_valid !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h11) begin tests_failed++; $display("FAIL rmid_first_served: got %b/%0d/%h want 1/0/11", tx_valid, grant_id, tx_data); end
  endtask

  task automatic test_idle_ready();
    int bad;
    apply_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tx_ready = 1'($urandom);
      cycle();
      if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL idle_ready: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(2, 0) == 0);
      req_data = {8'($urandom), 8'($urandom), 8'($urandom)};
      tx_ready = ($urandom_range(9, 0) < 6);
      cycle();
      tests_run++; if (tx_valid !== m_valid) begin tests_failed++; $display("FAIL rand_tx_valid@%0d: got %b want %b", c, tx_valid, m_valid); end
      tests_run++; if (tx_data !== m_txd || grant_id !== 2'(m_gid)) begin tests_failed++; $display("FAIL rand_data@%0d: got %h/%0d want %h/%0d", c, tx_data, grant_id, m_txd, m_gid); end
      tests_run++; if (req_ready !== m_ready()) begin tests_failed++; $display("FAIL rand_req_ready@%0d: got %b want %b", c, req_ready, m_ready()); end
      tests_run++; if (busy !== m_busy()) begin tests_failed++; $display("FAIL rand_busy@%0d: got %b want %b", c, busy, m_busy()); end
    end
    req_valid = '0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_all_three();
    test_stall();
    test_fairness();
    test_reset_mid();
    test_idle_ready();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
